// File: rtl/mem_stage.sv
// MEM pipeline stage: word load/store via a req/ack data-memory handshake with
// timeout and alignment checks, stall generation, and the MEM/WB pipeline register.
module mem_stage #(
    parameter int unsigned TIMEOUT = 16,
    parameter logic [5:0]  OP_LW   = 6'b100011,
    parameter logic [5:0]  OP_SW   = 6'b101011
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  op_mem,
    input  logic [31:0] alu_mem,
    input  logic [31:0] addr_mem,
    input  logic        ife_mem,
    input  logic [4:0]  Ri_mem,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    output logic        stall_o,
    output logic [5:0]  op_wb,
    output logic [31:0] wdata_wb,
    output logic [4:0]  Ri_wb,
    output logic        we_wb,
    output logic        ife_wb,
    output logic        bus_err,
    output logic        align_err
);

    localparam logic [7:0] TimeoutCnt = 8'(TIMEOUT);

    typedef enum logic {StIdle, StWait} state_t;

    state_t      r_state;
    logic [7:0]  r_cnt;

    logic w_is_mem;
    logic w_is_lw;
    logic w_aligned;
    logic w_wr_op;
    logic w_done;
    logic w_timeout;
    logic w_misalign;
    logic w_bubble;
    logic w_rd_nz;

    // Decode and memory-interface outputs; inputs are held by the stall while waiting.
    always_comb begin
        w_is_lw   = (op_mem == OP_LW);
        w_is_mem  = w_is_lw | (op_mem == OP_SW);
        w_aligned = (alu_mem[1:0] == 2'b00);
        w_wr_op   = (op_mem == 6'b000000) | (op_mem[5:3] == 3'b001) | w_is_lw;
        w_rd_nz   = (Ri_mem != 5'd0);

        if (rst) begin
            mem_req = 1'b0;
        end else if (r_state == StWait) begin
            mem_req = 1'b1;
        end else begin
            mem_req = w_is_mem & w_aligned;
        end
        mem_we    = ~rst & (op_mem == OP_SW);
        mem_addr  = alu_mem;
        mem_wdata = addr_mem;

        w_done     = mem_req & mem_ack;
        w_timeout  = ~rst & (r_state == StWait) & ~mem_ack & (r_cnt == TimeoutCnt);
        // Combinational ack->stall path: upstream unfreezes in the very cycle ack arrives.
        stall_o    = mem_req & ~mem_ack & ~w_timeout;
        w_misalign = (r_state == StIdle) & w_is_mem & ~w_aligned;
        w_bubble   = stall_o | w_timeout | w_misalign;
    end

    // Handshake FSM and wait-cycle counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= StIdle;
            r_cnt   <= 8'd0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (mem_req && !mem_ack) begin
                        r_state <= StWait;
                        r_cnt   <= 8'd1;
                    end else begin
                        r_cnt   <= 8'd0;
                    end
                end
                StWait: begin
                    if (mem_ack || w_timeout) begin
                        r_state <= StIdle;
                        r_cnt   <= 8'd0;
                    end else begin
                        r_cnt   <= r_cnt + 8'd1;
                    end
                end
                default: begin
                    r_state <= StIdle;
                    r_cnt   <= 8'd0;
                end
            endcase
        end
    end

    // MEM/WB register; bubbles suppress the write so a frozen upstream cannot write twice.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_wb     <= 6'd0;
            wdata_wb  <= 32'd0;
            Ri_wb     <= 5'd0;
            we_wb     <= 1'b0;
            ife_wb    <= 1'b0;
            bus_err   <= 1'b0;
            align_err <= 1'b0;
        end else begin
            op_wb     <= op_mem;
            ife_wb    <= ife_mem;
            bus_err   <= w_timeout;
            align_err <= w_misalign;
            wdata_wb  <= (w_is_lw && w_done) ? mem_rdata : alu_mem;
            if (w_bubble) begin
                we_wb <= 1'b0;
                Ri_wb <= 5'd0;
            end else begin
                Ri_wb <= Ri_mem;
                if (w_is_mem) begin
                    we_wb <= w_is_lw & w_done & w_rd_nz;
                end else begin
                    we_wb <= w_wr_op & w_rd_nz;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage with a scoreboard of expected MEM/WB contents.
module tb_mem_stage;

    localparam logic [5:0] LW  = 6'b100011;
    localparam logic [5:0] SW  = 6'b101011;
    localparam logic [5:0] ADD = 6'b000000;
    localparam logic [5:0] ADI = 6'b001000;
    localparam logic [5:0] NOP = 6'b000010;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  op_mem;
    logic [31:0] alu_mem;
    logic [31:0] addr_mem;
    logic        ife_mem;
    logic [4:0]  Ri_mem;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    logic        stall_o;
    logic [5:0]  op_wb;
    logic [31:0] wdata_wb;
    logic [4:0]  Ri_wb;
    logic        we_wb;
    logic        ife_wb;
    logic        bus_err;
    logic        align_err;

    typedef struct packed {
        logic [5:0]  op;
        logic [31:0] wdata;
        logic [4:0]  ri;
        logic        we;
        logic        ife;
        logic        berr;
        logic        aerr;
    } wb_t;

    wb_t sb_q[$];
    int  checks   = 0;
    int  failures = 0;

    mem_stage #(.TIMEOUT(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .op_mem    (op_mem),
        .alu_mem   (alu_mem),
        .addr_mem  (addr_mem),
        .ife_mem   (ife_mem),
        .Ri_mem    (Ri_mem),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack),
        .stall_o   (stall_o),
        .op_wb     (op_wb),
        .wdata_wb  (wdata_wb),
        .Ri_wb     (Ri_wb),
        .we_wb     (we_wb),
        .ife_wb    (ife_wb),
        .bus_err   (bus_err),
        .align_err (align_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One pipeline cycle: check combinational outputs, queue expected WB, clock, compare WB.
    task automatic step(input string tag, input logic e_req, input logic e_stall,
                        input wb_t e_wb);
        wb_t got;
        #1;
        chk({tag, ".mem_req"}, 32'(mem_req), 32'(e_req));
        chk({tag, ".stall_o"}, 32'(stall_o), 32'(e_stall));
        if (e_req) begin
            chk({tag, ".mem_we"}, 32'(mem_we), 32'(op_mem == SW));
            chk({tag, ".mem_addr"}, mem_addr, alu_mem);
            if (op_mem == SW) chk({tag, ".mem_wdata"}, mem_wdata, addr_mem);
        end
        sb_q.push_back(e_wb);
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            chk({tag, ".sb_empty"}, 32'd1, 32'd0);
        end else begin
            got = '{op: op_wb, wdata: wdata_wb, ri: Ri_wb, we: we_wb, ife: ife_wb,
                    berr: bus_err, aerr: align_err};
            e_wb = sb_q.pop_front();
            chk({tag, ".op_wb"}, 32'(got.op), 32'(e_wb.op));
            chk({tag, ".wdata_wb"}, got.wdata, e_wb.wdata);
            chk({tag, ".Ri_wb"}, 32'(got.ri), 32'(e_wb.ri));
            chk({tag, ".we_wb"}, 32'(got.we), 32'(e_wb.we));
            chk({tag, ".ife_wb"}, 32'(got.ife), 32'(e_wb.ife));
            chk({tag, ".bus_err"}, 32'(got.berr), 32'(e_wb.berr));
            chk({tag, ".align_err"}, 32'(got.aerr), 32'(e_wb.aerr));
        end
    endtask

    task automatic drive(input logic [5:0] op, input logic [31:0] alu, input logic [31:0] sd,
                         input logic [4:0] ri, input logic ife, input logic ack,
                         input logic [31:0] rd);
        op_mem = op; alu_mem = alu; addr_mem = sd; Ri_mem = ri;
        ife_mem = ife; mem_ack = ack; mem_rdata = rd;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".mem_req"}, 32'(mem_req), 32'd0);
        chk({tag, ".stall_o"}, 32'(stall_o), 32'd0);
        chk({tag, ".op_wb"}, 32'(op_wb), 32'd0);
        chk({tag, ".wdata_wb"}, wdata_wb, 32'd0);
        chk({tag, ".Ri_wb"}, 32'(Ri_wb), 32'd0);
        chk({tag, ".we_wb"}, 32'(we_wb), 32'd0);
        chk({tag, ".ife_wb"}, 32'(ife_wb), 32'd0);
        chk({tag, ".bus_err"}, 32'(bus_err), 32'd0);
        chk({tag, ".align_err"}, 32'(align_err), 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        drive(ADD, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 32'd0);
        #12;
        chk_all_zero("reset");
        rst = 1'b0;

        // ADD, no memory traffic
        drive(ADD, 32'h5, 32'h0, 5'd3, 1'b0, 1'b0, 32'h0);
        step("add", 1'b0, 1'b0, '{ADD, 32'h5, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0});

        // ADDI-class op writing r0 must not write
        drive(ADI, 32'h77, 32'h0, 5'd0, 1'b1, 1'b0, 32'h0);
        step("addi_r0", 1'b0, 1'b0, '{ADI, 32'h77, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0});

        // LW zero-wait
        drive(LW, 32'h100, 32'h0, 5'd8, 1'b0, 1'b1, 32'hDEAD_BEEF);
        step("lw0", 1'b1, 1'b0, '{LW, 32'hDEAD_BEEF, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0});

        // SW acked after 3 stall cycles
        drive(SW, 32'h200, 32'h1234, 5'd7, 1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            step("sw_wait", 1'b1, 1'b1, '{SW, 32'h200, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0});
        end
        mem_ack = 1'b1;
        step("sw_ack", 1'b1, 1'b0, '{SW, 32'h200, 5'd7, 1'b0, 1'b0, 1'b0, 1'b0});

        // LW timeout: IDLE + 3 WAIT stall cycles, 4th WAIT aborts
        drive(LW, 32'h300, 32'h0, 5'd9, 1'b0, 1'b0, 32'hBAD0_BAD0);
        for (int i = 0; i < 4; i++) begin
            step("to_wait", 1'b1, 1'b1, '{LW, 32'h300, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0});
        end
        step("to_abort", 1'b1, 1'b0, '{LW, 32'h300, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0});
        drive(NOP, 32'h0, 32'h0, 5'd1, 1'b0, 1'b0, 32'h0);
        step("to_after", 1'b0, 1'b0, '{NOP, 32'h0, 5'd1, 1'b0, 1'b0, 1'b0, 1'b0});

        // Misaligned LW
        drive(LW, 32'h102, 32'h0, 5'd4, 1'b0, 1'b1, 32'h1111_1111);
        step("misal", 1'b0, 1'b0, '{LW, 32'h102, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1});
        drive(ADD, 32'h6, 32'h0, 5'd4, 1'b0, 1'b0, 32'h0);
        step("misal_after", 1'b0, 1'b0, '{ADD, 32'h6, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0});

        // Reset mid-WAIT, then a late ack with no request
        drive(LW, 32'h400, 32'h0, 5'd6, 1'b0, 1'b0, 32'h0);
        step("rw_idle", 1'b1, 1'b1, '{LW, 32'h400, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0});
        step("rw_wait", 1'b1, 1'b1, '{LW, 32'h400, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0});
        rst = 1'b1;
        #1;
        chk_all_zero("rst_async");
        @(posedge clk);
        #2;
        rst = 1'b0;
        drive(NOP, 32'h44, 32'h0, 5'd5, 1'b0, 1'b1, 32'hCAFE_F00D);
        step("late_ack", 1'b0, 1'b0, '{NOP, 32'h44, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0});
        drive(ADD, 32'h9, 32'h0, 5'd2, 1'b1, 1'b0, 32'h0);
        step("post_rst", 1'b0, 1'b0, '{ADD, 32'h9, 5'd2, 1'b1, 1'b1, 1'b0, 1'b0});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global time bound so the run always terminates.
    initial begin
        #20000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "bench time limit reached");
    end

endmodule
